// File: rtl/pll_lock_sequencer.sv
// PLL bring-up sequencer: pulses the PLL reset, qualifies lock with bounded retries,
// then releases downstream domain resets in a staggered order and tears down on lock loss.
module pll_lock_sequencer #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRIES         = 3,
  parameter int NUM_DOMAINS         = 3,
  parameter int RELEASE_GAP         = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   pll_locked,
  input  logic                   restart_req,
  output logic                   pll_rst,
  output logic [NUM_DOMAINS-1:0] domain_reset_n,
  output logic                   ready,
  output logic                   fail,
  output logic [3:0]             retry_count,
  output logic [7:0]             lock_loss_count,
  output logic [2:0]             state_o
);

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RELEASE   = 3'd3,
    S_RUN       = 3'd4,
    S_FAIL      = 3'd5
  } state_t;

  // Counter must hold the longest window of any state, including the release span.
  localparam int REL_SPAN = RELEASE_GAP * (NUM_DOMAINS - 1) + 1;
  localparam int MAX_A    = (RST_PULSE_CYCLES > LOCK_STABLE_CYCLES) ? RST_PULSE_CYCLES : LOCK_STABLE_CYCLES;
  localparam int MAX_B    = (LOCK_TIMEOUT_CYCLES > REL_SPAN) ? LOCK_TIMEOUT_CYCLES : REL_SPAN;
  localparam int MAXC     = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW       = $clog2(MAXC + 1);

  localparam logic [CW-1:0] RST_LAST = CW'(RST_PULSE_CYCLES - 1);
  localparam logic [CW-1:0] STB_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] REL_LAST = CW'(RELEASE_GAP * (NUM_DOMAINS - 1));

  state_t                 state_q;
  logic [CW-1:0]          cnt_q;
  logic [1:0]             sync_q;
  logic                   pll_rst_q;
  logic [NUM_DOMAINS-1:0] dom_q;
  logic                   ready_q;
  logic                   fail_q;
  logic [3:0]             retry_q;
  logic [7:0]             llc_q;
  logic                   lock_s;

  assign lock_s = sync_q[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], pll_locked};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_RESET_PLL;
      cnt_q     <= '0;
      pll_rst_q <= 1'b1;
      dom_q     <= '0;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
      retry_q   <= 4'd0;
      llc_q     <= 8'd0;
    end else if (restart_req && (state_q != S_RESET_PLL)) begin
      // Restart outranks lock loss, so the lock-loss counter is left alone here.
      state_q   <= S_RESET_PLL;
      cnt_q     <= '0;
      pll_rst_q <= 1'b1;
      dom_q     <= '0;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
      retry_q   <= 4'd0;
    end else begin
      case (state_q)
        S_RESET_PLL: begin
          if (cnt_q == RST_LAST) begin
            state_q   <= S_WAIT_LOCK;
            cnt_q     <= '0;
            pll_rst_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_WAIT_LOCK: begin
          if (lock_s) begin
            state_q <= S_STABLE;
            cnt_q   <= '0;
          end else if (cnt_q == TO_LAST) begin
            cnt_q     <= '0;
            pll_rst_q <= 1'b1;
            if (retry_q < 4'(MAX_RETRIES)) begin
              state_q <= S_RESET_PLL;
              retry_q <= retry_q + 4'd1;
            end else begin
              state_q <= S_FAIL;
              fail_q  <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_STABLE: begin
          if (!lock_s) begin
            state_q <= S_WAIT_LOCK;
            cnt_q   <= '0;
          end else if (cnt_q == STB_LAST) begin
            state_q <= S_RELEASE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_RELEASE, S_RUN: begin
          if (!lock_s) begin
            state_q   <= S_RESET_PLL;
            cnt_q     <= '0;
            pll_rst_q <= 1'b1;
            dom_q     <= '0;
            ready_q   <= 1'b0;
            retry_q   <= 4'd0;
            if (llc_q != 8'hFF) llc_q <= llc_q + 8'd1;
          end else if (state_q == S_RELEASE) begin
            for (int k = 0; k < NUM_DOMAINS; k++) begin
              if (cnt_q == CW'(k * RELEASE_GAP)) dom_q[k] <= 1'b1;
            end
            if (cnt_q == REL_LAST) begin
              state_q <= S_RUN;
              cnt_q   <= '0;
              ready_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        S_FAIL: begin
          pll_rst_q <= 1'b1;
          fail_q    <= 1'b1;
          dom_q     <= '0;
        end
        default: begin
          state_q   <= S_RESET_PLL;
          cnt_q     <= '0;
          pll_rst_q <= 1'b1;
          dom_q     <= '0;
          ready_q   <= 1'b0;
        end
      endcase
    end
  end

  assign pll_rst         = pll_rst_q;
  assign domain_reset_n  = dom_q;
  assign ready           = ready_q;
  assign fail            = fail_q;
  assign retry_count     = retry_q;
  assign lock_loss_count = llc_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer: bring-up, glitch, timeout/fail, lock loss,
// restart and asynchronous reset scenarios with hand-computed cycle counts.
module tb_pll_lock_sequencer;

  localparam int P = 4;
  localparam int S = 8;
  localparam int T = 32;
  localparam int R = 2;
  localparam int N = 3;
  localparam int G = 2;

  localparam logic [2:0] ST_RESET = 3'd0;
  localparam logic [2:0] ST_RUN   = 3'd4;
  localparam logic [2:0] ST_FAIL  = 3'd5;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         pll_locked = 1'b0;
  logic         restart_req = 1'b0;
  logic         pll_rst;
  logic [N-1:0] domain_reset_n;
  logic         ready;
  logic         fail;
  logic [3:0]   retry_count;
  logic [7:0]   lock_loss_count;
  logic [2:0]   state_o;

  int vectors = 0;
  int miscompares = 0;
  int hi, lo, n, rst_seen;

  pll_lock_sequencer #(
    .RST_PULSE_CYCLES(P), .LOCK_STABLE_CYCLES(S), .LOCK_TIMEOUT_CYCLES(T),
    .MAX_RETRIES(R), .NUM_DOMAINS(N), .RELEASE_GAP(G)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pll_locked(pll_locked), .restart_req(restart_req),
    .pll_rst(pll_rst), .domain_reset_n(domain_reset_n), .ready(ready), .fail(fail),
    .retry_count(retry_count), .lock_loss_count(lock_loss_count), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic measure_hi(output int cnt);
    cnt = 0;
    while (pll_rst === 1'b1 && cnt < 200) begin cnt++; @(negedge clk); end
  endtask

  task automatic measure_lo(output int cnt);
    cnt = 0;
    while (pll_rst === 1'b0 && cnt < 200) begin cnt++; @(negedge clk); end
  endtask

  task automatic wait_dom(output int cnt, output int rst_hi);
    cnt = 0;
    rst_hi = 0;
    while (domain_reset_n === '0 && cnt < 200) begin
      if (pll_rst === 1'b1) rst_hi++;
      @(negedge clk);
      cnt++;
    end
  endtask

  task automatic wait_ready(input string tag);
    int k;
    k = 0;
    while (ready !== 1'b1 && k < 200) begin @(negedge clk); k++; end
    check(tag, ready, 1);
  endtask

  task automatic apply_reset(input string tag);
    @(negedge clk);
    reset_n = 1'b0;
    tick(2);
    check({tag, "_rst_pll_rst"}, pll_rst, 1);
    check({tag, "_rst_dom"}, domain_reset_n, 0);
    check({tag, "_rst_ready"}, ready, 0);
    check({tag, "_rst_fail"}, fail, 0);
    check({tag, "_rst_retry"}, retry_count, 0);
    check({tag, "_rst_llc"}, lock_loss_count, 0);
    check({tag, "_rst_state"}, state_o, ST_RESET);
    reset_n = 1'b1;
  endtask

  initial begin
    // 1: nominal bring-up
    apply_reset("t1");
    measure_hi(hi);
    check("t1_pulse_len", hi, P);
    tick(5);
    pll_locked = 1'b1;
    wait_dom(n, rst_seen);
    check("t1_release_latency", n, 12);
    check("t1_dom_001", domain_reset_n, 3'b001);
    check("t1_ready_early", ready, 0);
    tick(1); check("t1_dom_001b", domain_reset_n, 3'b001);
    tick(1); check("t1_dom_011", domain_reset_n, 3'b011);
    check("t1_ready_mid", ready, 0);
    tick(1); check("t1_dom_011b", domain_reset_n, 3'b011);
    tick(1); check("t1_dom_111", domain_reset_n, 3'b111);
    check("t1_ready", ready, 1);
    check("t1_retry", retry_count, 0);
    check("t1_state_run", state_o, ST_RUN);

    // 4: lock loss in RUN, then relock
    pll_locked = 1'b0;
    tick(2);
    check("t4_ready_before_loss", ready, 1);
    tick(1);
    check("t4_dom_clear", domain_reset_n, 3'b000);
    check("t4_ready_clear", ready, 0);
    check("t4_pll_rst", pll_rst, 1);
    check("t4_llc", lock_loss_count, 1);
    check("t4_state", state_o, ST_RESET);
    pll_locked = 1'b1;
    wait_ready("t4_relock_ready");
    check("t4_relock_dom", domain_reset_n, 3'b111);
    check("t4_relock_llc", lock_loss_count, 1);

    // 5b: restart coincident with lock loss
    pll_locked = 1'b0;
    tick(2);
    restart_req = 1'b1;
    tick(1);
    restart_req = 1'b0;
    check("t5b_dom", domain_reset_n, 3'b000);
    check("t5b_ready", ready, 0);
    check("t5b_pll_rst", pll_rst, 1);
    check("t5b_llc_unchanged", lock_loss_count, 1);
    check("t5b_retry", retry_count, 0);
    measure_hi(hi);
    check("t5b_pulse_len", hi, P);

    // 2: one-cycle lock glitch during STABLE
    apply_reset("t2");
    measure_hi(hi);
    check("t2_pulse_len", hi, P);
    pll_locked = 1'b1;
    tick(5);
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    wait_dom(n, rst_seen);
    check("t2_release_latency", n, 12);
    check("t2_no_pll_rst", rst_seen, 0);
    check("t2_dom_001", domain_reset_n, 3'b001);
    wait_ready("t2_ready");
    check("t2_retry", retry_count, 0);

    // 6: asynchronous reset in the middle of RELEASE
    pll_locked = 1'b0;
    apply_reset("t6");
    measure_hi(hi);
    check("t6_pulse_len", hi, P);
    pll_locked = 1'b1;
    wait_dom(n, rst_seen);
    tick(2);
    check("t6_dom_011", domain_reset_n, 3'b011);
    #2 reset_n = 1'b0;
    #1;
    check("t6_async_dom", domain_reset_n, 3'b000);
    check("t6_async_pll_rst", pll_rst, 1);
    check("t6_async_ready", ready, 0);
    check("t6_async_state", state_o, ST_RESET);
    @(negedge clk);
    reset_n = 1'b1;
    measure_hi(hi);
    check("t6_restart_pulse", hi, P);
    wait_ready("t6_ready");
    check("t6_dom_111", domain_reset_n, 3'b111);

    // 3: never lock -> retries then FAIL
    pll_locked = 1'b0;
    apply_reset("t3");
    for (int a = 0; a <= R; a++) begin
      check("t3_retry_at_pulse", retry_count, a);
      measure_hi(hi);
      check("t3_pulse_len", hi, P);
      measure_lo(lo);
      check("t3_wait_len", lo, T);
    end
    check("t3_fail", fail, 1);
    check("t3_pll_rst", pll_rst, 1);
    check("t3_ready", ready, 0);
    check("t3_retry_final", retry_count, R);
    check("t3_state", state_o, ST_FAIL);
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (pll_rst !== 1'b1 || fail !== 1'b1) n++;
    end
    check("t3_held_in_fail", n, 0);

    // 5a: restart from FAIL
    restart_req = 1'b1;
    tick(1);
    restart_req = 1'b0;
    check("t5a_fail_clear", fail, 0);
    check("t5a_retry_clear", retry_count, 0);
    check("t5a_state", state_o, ST_RESET);
    measure_hi(hi);
    check("t5a_pulse_len", hi, P);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Sequences bring-up of the system PLL (3 output clocks, 50 MHz reference) and owns its reset input.
- Pulses the PLL reset, then waits for a qualified lock. On lock timeout it retries a bounded number of times.
- After lock, releases per-domain resets in a fixed staggered order and tears everything down again on lock loss or on a software restart request.
- Runs on the reference clock domain, ahead of all PLL-derived logic.

Parameters:
- RST_PULSE_CYCLES, 16: cycles pll_rst is held high per attempt (≥1).
- LOCK_STABLE_CYCLES, 1024: consecutive synchronized-lock cycles required before release (≥1).
- LOCK_TIMEOUT_CYCLES, 65536: cycles allowed in WAIT_LOCK before an attempt fails (≥1).
- MAX_RETRIES, 3: extra attempts after the first before FAIL (0..15).
- NUM_DOMAINS, 3: number of downstream reset outputs (1..8).
- RELEASE_GAP, 4: cycles between successive domain reset releases (≥1).

Ports:
- clk  in  1  reference clock (50 MHz), same source as PLL refclk.
- reset_n  in  1  asynchronous, active-low reset.
- pll_locked  in  1  PLL locked indication, asynchronous to clk.
- restart_req  in  1  single-cycle restart pulse, synchronous to clk.
- pll_rst  out  1  active-high reset to PLL.
- domain_reset_n  out  NUM_DOMAINS  active-low resets for derived clock domains; bit 0 is released first.
- ready  out  1  all domains out of reset, PLL locked.
- fail  out  1  retries exhausted.
- retry_count  out  4  attempts failed since last clean start.
- lock_loss_count  out  8  lock drops seen in RELEASE/RUN; saturates at 255.

Behaviour:
- Reset values while reset_n=0: pll_rst=1, domain_reset_n=all 0, ready=0, fail=0, retry_count=0, lock_loss_count=0, state=RESET_PLL, counters=0.
- All outputs are registered.
- pll_locked passes through a 2-flop synchronizer (lock_s, 2-cycle latency); only lock_s is used.
- One shared cycle counter; it clears on every state entry. Width is clog2 of the largest count parameter.
- RESET_PLL:
  - pll_rst=1 for exactly RST_PULSE_CYCLES cycles, then go to WAIT_LOCK.
  - restart_req is ignored in this state.
- WAIT_LOCK:
  - pll_rst=0. lock_s=1 → go to STABLE.
  - Counter reaches LOCK_TIMEOUT_CYCLES without lock → timeout:
    - if retry_count<MAX_RETRIES: retry_count+1, go to RESET_PLL;
    - else go to FAIL.
- STABLE:
  - lock_s=1 for LOCK_STABLE_CYCLES consecutive cycles → go to RELEASE.
  - lock_s=0 → go to WAIT_LOCK with a fresh timeout window; this is not a retry and not a lock loss.
- RELEASE:
  - domain_reset_n[0] deasserts on the first cycle after entry.
  - Bit k deasserts RELEASE_GAP·k cycles after bit 0. Bits only ever go 0→1 in index order.
  - When the last bit deasserts, go to RUN; ready=1 on the same edge.
- RUN:
  - Hold outputs.
  - lock_s=0 → lock_loss_count+1 (saturating), retry_count=0, go to RESET_PLL.
- Lock loss in RELEASE or RUN:
  - on the next edge, domain_reset_n=all 0, ready=0, pll_rst=1;
  - state goes to RESET_PLL.
- FAIL: pll_rst=1, fail=1, domain_reset_n=0. Held until restart_req or reset_n.
- restart_req in any state except RESET_PLL:
  - next edge goes to RESET_PLL;
  - clears retry_count and fail;
  - asserts all domain resets; ready=0.
- Simultaneous restart_req and lock loss: restart wins; lock_loss_count is not incremented.
- Simultaneous timeout and lock_s rising in WAIT_LOCK: lock wins (go to STABLE).
- reset_n assertion mid-operation: immediate asynchronous return to reset values; lock_loss_count is cleared.
- retry_count never exceeds MAX_RETRIES.

Test Plan (bench params: RST_PULSE_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, MAX_RETRIES=2, NUM_DOMAINS=3, RELEASE_GAP=2):
1. Nominal bring-up: release reset_n, raise pll_locked 5 cycles after pll_rst falls → pll_rst high exactly 4 cycles; domain_reset_n steps 000→001→011→111 at 2-cycle spacing; ready=1 with 111; retry_count=0.
2. Lock glitch in STABLE: drop pll_locked for 1 cycle after 5 locked cycles → stays in bring-up, no pll_rst pulse; release begins only after 8 further consecutive lock_s cycles; retry_count=0.
3. Never lock: pll_locked held 0 → three pll_rst pulses of 4 cycles, each followed by a 32-cycle wait; retry_count 0→1→2; then fail=1, pll_rst=1, ready=0 and no further pulses.
4. Lock loss in RUN: after ready, drop pll_locked → within 3 cycles domain_reset_n=000, ready=0, pll_rst=1; lock_loss_count=1; relock restores ready.
5. Restart from FAIL, and restart_req coincident with lock loss in RUN → fail=0, retry_count=0, fresh 4-cycle pll_rst pulse; for the coincident case lock_loss_count is unchanged.
6. reset_n asserted mid-RELEASE (domain_reset_n=011) → all outputs at reset values asynchronously; sequence restarts cleanly on deassert.
